// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and mixer state encoding
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int UNITY_SHIFT = 7;
  localparam int SAMPLE_MAX  = 32767;
  localparam int SAMPLE_MIN  = -32768;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    OUT
  } mix_state_e;
endpackage

// File: rtl/sfx_mac.sv
// rtl/sfx_mac.sv - signed sample x unsigned gain multiply-accumulate with
// unity-shift and 16-bit saturation of the accumulated sum
module sfx_mac
  import audio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int GAIN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [SAMPLE_W-1:0] sat_value,
  output logic                       sat_clip
);
  // Headroom of clog2(NUM_CH) bits keeps the worst-case sum from wrapping
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  shifted;

  always_comb begin
    prod = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
  end

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Arithmetic shift floors toward minus infinity, then clamp to 16 bits
  always_comb begin
    shifted   = acc_q >>> UNITY_SHIFT;
    sat_value = shifted[SAMPLE_W-1:0];
    sat_clip  = 1'b0;
    if (shifted > ACC_W'(SAMPLE_MAX)) begin
      sat_value = SAMPLE_W'(SAMPLE_MAX);
      sat_clip  = 1'b1;
    end else if (shifted < ACC_W'(SAMPLE_MIN)) begin
      sat_value = SAMPLE_W'(SAMPLE_MIN);
      sat_clip  = 1'b1;
    end
  end
endmodule

// File: rtl/sfx_mixer.sv
// rtl/sfx_mixer.sv - sequential N-channel gain mixer: snapshots inputs on the
// 48 kHz strobe, accumulates one channel per cycle, saturates and emits
module sfx_mixer
  import audio_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int GAIN_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_48KHz_en,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_audio,
  input  logic [NUM_CH*GAIN_W-1:0]   ch_gain,
  input  logic                       mute,
  output logic [SAMPLE_W-1:0]        audio,
  output logic                       audio_valid,
  output logic                       clip,
  output logic                       overrun
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mix_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_CH*SAMPLE_W-1:0] audio_snap_q, audio_snap_d;
  logic [NUM_CH*GAIN_W-1:0]   gain_snap_q, gain_snap_d;
  logic [SAMPLE_W-1:0]        audio_q, audio_d;
  logic                       valid_q, valid_d;
  logic                       clip_q, clip_d;
  logic                       overrun_q, overrun_d;

  logic                       mac_clear;
  logic                       mac_en;
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic [GAIN_W-1:0]          cur_gain;
  logic signed [SAMPLE_W-1:0] sat_value;
  logic                       sat_clip;

  always_comb begin
    cur_sample = '0;
    cur_gain   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_sample = audio_snap_q[k*SAMPLE_W +: SAMPLE_W];
        cur_gain   = gain_snap_q[k*GAIN_W +: GAIN_W];
      end
    end
  end

  sfx_mac #(
    .NUM_CH(NUM_CH),
    .GAIN_W(GAIN_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (mac_clear),
    .en       (mac_en),
    .sample   (cur_sample),
    .gain     (cur_gain),
    .sat_value(sat_value),
    .sat_clip (sat_clip)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    audio_snap_d = audio_snap_q;
    gain_snap_d  = gain_snap_q;
    audio_d      = audio_q;
    clip_d       = clip_q;
    valid_d      = 1'b0;
    mac_clear    = 1'b0;
    mac_en       = 1'b0;
    // A strobe anywhere but IDLE is dropped and latched as an overrun
    overrun_d    = overrun_q | (clk_48KHz_en && (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (clk_48KHz_en) begin
          audio_snap_d = ch_audio;
          gain_snap_d  = ch_gain;
          idx_d        = '0;
          mac_clear    = 1'b1;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        mac_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = SAT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SAT: begin
        // Outputs register here so audio_valid is high during OUT
        audio_d = mute ? '0 : sat_value;
        clip_d  = mute ? 1'b0 : sat_clip;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      audio_snap_q <= '0;
      gain_snap_q  <= '0;
      audio_q      <= '0;
      valid_q      <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      audio_snap_q <= audio_snap_d;
      gain_snap_q  <= gain_snap_d;
      audio_q      <= audio_d;
      valid_q      <= valid_d;
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
    end
  end

  assign audio       = audio_q;
  assign audio_valid = valid_q;
  assign clip        = clip_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_sfx_mixer.sv
// tb/tb_sfx_mixer.sv - table-driven scoreboard bench for sfx_mixer (NUM_CH=4)
module tb_sfx_mixer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_48KHz_en;
  logic [63:0] ch_audio;
  logic [31:0] ch_gain;
  logic        mute;
  logic [15:0] audio;
  logic        audio_valid;
  logic        clip;
  logic        overrun;

  sfx_mixer #(
    .NUM_CH(4),
    .GAIN_W(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_48KHz_en(clk_48KHz_en),
    .ch_audio    (ch_audio),
    .ch_gain     (ch_gain),
    .mute        (mute),
    .audio       (audio),
    .audio_valid (audio_valid),
    .clip        (clip),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string            name;
    logic [3:0][15:0] smp;
    logic [3:0][7:0]  gn;
    logic             mute;
    int               exp_audio;
    int               exp_clip;
  } vec_t;

  typedef struct {
    int audio;
    int clip;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_audio = 0;
  int   last_clip = 0;
  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int s0, input int s1, input int s2,
                              input int s3, input int g0, input int g1, input int g2,
                              input int g3, input bit m, input int ea, input int ec);
    vec_t v;
    v.name      = nm;
    v.smp[0]    = 16'(s0);
    v.smp[1]    = 16'(s1);
    v.smp[2]    = 16'(s2);
    v.smp[3]    = 16'(s3);
    v.gn[0]     = 8'(g0);
    v.gn[1]     = 8'(g1);
    v.gn[2]     = 8'(g2);
    v.gn[3]     = 8'(g3);
    v.mute      = m;
    v.exp_audio = ea;
    v.exp_clip  = ec;
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (audio_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got audio_valid=1 at cycle %0d expected no output", cyc);
      end else begin
        e = sb.pop_front();
        chk("audio", int'($signed(audio)), e.audio);
        chk("clip", int'(clip), e.clip);
        chk("latency", cyc - e.cyc, 6);
        last_audio = e.audio;
        last_clip  = e.clip;
      end
    end
  end

  // Inputs are scrambled right after the strobe to prove the snapshot holds
  task automatic strobe(input vec_t v, input bit track);
    @(negedge clk);
    ch_audio     = v.smp;
    ch_gain      = v.gn;
    mute         = v.mute;
    clk_48KHz_en = 1'b1;
    if (track) sb.push_back('{v.exp_audio, v.exp_clip, cyc});
    @(negedge clk);
    clk_48KHz_en = 1'b0;
    ch_audio     = {$urandom, $urandom};
    ch_gain      = $urandom;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    strobe(v, 1'b1);
    drain(v.name);
    repeat (2) @(negedge clk);
    chk({v.name, "_hold_audio"}, int'($signed(audio)), last_audio);
    chk({v.name, "_hold_clip"}, int'(clip), last_clip);
    mute = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b1;
    clk_48KHz_en = 1'b0;
    ch_audio     = '0;
    ch_gain      = '0;
    mute         = 1'b0;

    vecs[0]  = mk("unity_ch0",  1000, 5000, -7000, 123, 128, 0, 0, 0, 0, 1000, 0);
    vecs[1]  = mk("pos_clip",   20000, 20000, 20000, 20000, 128, 128, 128, 128, 0, 32767, 1);
    vecs[2]  = mk("neg_clip",   -20000, -20000, -20000, -20000, 128, 128, 128, 128, 0, -32768, 1);
    vecs[3]  = mk("floor_neg",  -3, 0, 0, 0, 64, 0, 0, 0, 0, -2, 0);
    vecs[4]  = mk("floor_pos",  3, 0, 0, 0, 64, 0, 0, 0, 0, 1, 0);
    vecs[5]  = mk("mute",       1000, 0, 0, 0, 128, 0, 0, 0, 1, 0, 0);
    vecs[6]  = mk("mixed",      100, 200, -50, 7, 128, 255, 64, 1, 0, 473, 0);
    vecs[7]  = mk("mute_clip",  20000, 20000, 20000, 20000, 128, 128, 128, 128, 1, 0, 0);
    vecs[8]  = mk("max_noclip", 32767, 0, 0, 0, 128, 0, 0, 0, 0, 32767, 0);
    vecs[9]  = mk("min_noclip", -32768, 0, 0, 0, 128, 0, 0, 0, 0, -32768, 0);
    vecs[10] = mk("full_pos",   32767, 32767, 32767, 32767, 255, 255, 255, 255, 0, 32767, 1);
    vecs[11] = mk("full_neg",   -32768, -32768, -32768, -32768, 255, 255, 255, 255, 0, -32768, 1);
    vecs[12] = mk("tiny_neg",   -1, 0, 0, 0, 1, 0, 0, 0, 0, -1, 0);
    vecs[13] = mk("tiny_pos",   1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk("cancel",     20000, -20000, 0, 5, 128, 128, 0, 0, 0, 0, 0);

    #1 reset_n = 1'b0;
    #3;
    chk("rst_audio", int'(audio), 0);
    chk("rst_valid", int'(audio_valid), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_overrun", int'(overrun), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
    chk("no_overrun_yet", int'(overrun), 0);

    // Second strobe two cycles after the first must be dropped
    strobe(vecs[0], 1'b1);
    strobe(vecs[1], 1'b0);
    drain("overrun_seq");
    repeat (3) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_audio", int'($signed(audio)), 1000);
    run_vec(vecs[6]);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of ACCUM
    run_vec(vecs[1]);
    strobe(vecs[0], 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_audio", int'(audio), 0);
    chk("midrst_clip", int'(clip), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_valid", int'(audio_valid), 0);
    last_audio = 0;
    last_clip  = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle_audio", int'(audio), 0);
    run_vec(vecs[6]);
    chk("post_rst_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
